pam4_frame_sync: RTL and testbench

- Downstream consumer of the baud-rate PAM4 CDR core's symbol strobe and quantizer level.
- Gray-decodes each PAM4 symbol to 2 bits and packs 4 symbols (MSB-first) into bytes.
- Aligns to a periodic SYNC byte through a HUNT/VERIFY/LOCKED FSM.
- Delivers payload bytes through a small valid/ready FIFO for the chip-level debug/readout path.

---
 rtl/cdr_pkg.sv | 35 +++
 rtl/pam4_byte_fifo.sv | 65 ++++++
 rtl/pam4_frame_sync.sv | 199 +++++++++++++++++++
 tb/tb_pam4_frame_sync.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdr_pkg
// Brief    : Shared types and PAM4 symbol helpers for the frame-sync path.
// Revision : 1.0
// ============================================================================
package cdr_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        VERIFY = 2'b01,
        LOCKED = 2'b10
    } sync_state_t;

    // Two's-complement quantizer levels as seen on the 4-bit s_in bus.
    localparam logic [3:0] PAM4_M3 = 4'b1101;
    localparam logic [3:0] PAM4_M1 = 4'b1111;
    localparam logic [3:0] PAM4_P1 = 4'b0001;
    localparam logic [3:0] PAM4_P3 = 4'b0011;

    // Returns {valid, bits[1:0]}; invalid levels decode to bits 00.
    function automatic logic [2:0] pam4_gray_decode(input logic [3:0] level);
        logic [2:0] result;
        case (level)
            PAM4_M3: result = 3'b100;
            PAM4_M1: result = 3'b101;
            PAM4_P1: result = 3'b111;
            PAM4_P3: result = 3'b110;
            default: result = 3'b000;
        endcase
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pam4_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pam4_byte_fifo
// Brief    : Synchronous show-ahead FIFO; a write while full is accepted only
//            when a read happens in the same cycle.
// Revision : 1.0
// ============================================================================
module pam4_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define the contents.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pam4_frame_sync.sv
`default_nettype none
// ============================================================================
// Module   : pam4_frame_sync
// Brief    : PAM4 symbol-to-byte packer with SYNC-byte frame alignment and a
//            payload output FIFO.
// Revision : 1.0
// ============================================================================
module pam4_frame_sync
    import cdr_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE  = 8'h3C,
    parameter int         FRAME_LEN  = 16,
    parameter int         VERIFY_N   = 2,
    parameter int         LOSS_N     = 3,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en,
    input  logic [3:0] s_in,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       locked,
    output logic [1:0] state,
    output logic [7:0] sym_err_cnt,
    output logic       overflow
);

    localparam logic [7:0] LAST_IDX   = 8'(FRAME_LEN - 1);
    localparam logic [7:0] VERIFY_TGT = 8'(VERIFY_N);
    localparam logic [7:0] LOSS_TGT   = 8'(LOSS_N);

    sync_state_t r_state,       w_state;
    logic [7:0]  r_sr,          w_sr;
    logic [1:0]  r_sym_phase,   w_sym_phase;
    logic [7:0]  r_byte_idx,    w_byte_idx;
    logic [7:0]  r_verify_cnt,  w_verify_cnt;
    logic [7:0]  r_miss_cnt,    w_miss_cnt;
    logic [7:0]  r_sym_err_cnt, w_sym_err_cnt;
    logic        r_overflow,    w_overflow;
    logic        r_wr_en,       w_wr_en;
    logic [7:0]  r_wr_data,     w_wr_data;

    logic [2:0]  w_dec;
    logic        w_sym_ok;
    logic [7:0]  w_sr_shift;
    logic        w_byte_done;
    logic        w_is_sync;
    logic        w_at_sync;
    logic [7:0]  w_verify_inc;
    logic [7:0]  w_miss_inc;

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_fifo_rd;
    logic [7:0]  w_fifo_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HUNT;
            r_sr          <= '0;
            r_sym_phase   <= '0;
            r_byte_idx    <= '0;
            r_verify_cnt  <= '0;
            r_miss_cnt    <= '0;
            r_sym_err_cnt <= '0;
            r_overflow    <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_data     <= '0;
        end else begin
            r_state       <= w_state;
            r_sr          <= w_sr;
            r_sym_phase   <= w_sym_phase;
            r_byte_idx    <= w_byte_idx;
            r_verify_cnt  <= w_verify_cnt;
            r_miss_cnt    <= w_miss_cnt;
            r_sym_err_cnt <= w_sym_err_cnt;
            r_overflow    <= w_overflow;
            r_wr_en       <= w_wr_en;
            r_wr_data     <= w_wr_data;
        end
    end

    always_comb begin
        w_dec        = pam4_gray_decode(s_in);
        w_sym_ok     = w_dec[2];
        w_sr_shift   = {r_sr[5:0], w_dec[1:0]};
        w_byte_done  = sample_en && (r_sym_phase == 2'd3);
        w_is_sync    = (w_sr_shift == SYNC_BYTE);
        w_at_sync    = (r_byte_idx == 8'd0);
        w_verify_inc = r_verify_cnt + 8'd1;
        w_miss_inc   = r_miss_cnt + 8'd1;

        w_state       = r_state;
        w_sr          = r_sr;
        w_sym_phase   = r_sym_phase;
        w_byte_idx    = r_byte_idx;
        w_verify_cnt  = r_verify_cnt;
        w_miss_cnt    = r_miss_cnt;
        w_sym_err_cnt = r_sym_err_cnt;
        w_wr_en       = 1'b0;
        w_wr_data     = r_wr_data;
        w_overflow    = r_overflow;

        // The registered write lands one cycle later; drop it if no room.
        if (r_wr_en && w_fifo_full && !w_fifo_rd) begin
            w_overflow = 1'b1;
        end

        if (sample_en) begin
            w_sr = w_sr_shift;
            if (!w_sym_ok && (r_sym_err_cnt != 8'hFF)) begin
                w_sym_err_cnt = r_sym_err_cnt + 8'd1;
            end

            case (r_state)
                HUNT: begin
                    if (w_sym_ok && w_is_sync) begin
                        w_state      = VERIFY;
                        w_sym_phase  = 2'd0;
                        w_byte_idx   = 8'd1;
                        w_verify_cnt = 8'd1;
                        w_miss_cnt   = 8'd0;
                    end
                end

                VERIFY, LOCKED: begin
                    w_sym_phase = r_sym_phase + 2'd1;
                    if (w_byte_done) begin
                        w_byte_idx = (r_byte_idx == LAST_IDX) ? 8'd0 : r_byte_idx + 8'd1;
                    end

                    if (r_state == VERIFY) begin
                        if (!w_sym_ok) begin
                            w_state      = HUNT;
                            w_verify_cnt = 8'd0;
                            w_miss_cnt   = 8'd0;
                        end else if (w_byte_done && w_at_sync) begin
                            if (w_is_sync) begin
                                w_verify_cnt = w_verify_inc;
                                if (w_verify_inc == VERIFY_TGT) begin
                                    w_state    = LOCKED;
                                    w_miss_cnt = 8'd0;
                                end
                            end else begin
                                w_state      = HUNT;
                                w_verify_cnt = 8'd0;
                                w_miss_cnt   = 8'd0;
                            end
                        end
                    end else if (w_byte_done) begin
                        if (!w_at_sync) begin
                            w_wr_en   = 1'b1;
                            w_wr_data = w_sr_shift;
                        end else if (w_is_sync) begin
                            w_miss_cnt = 8'd0;
                        end else if (w_miss_inc == LOSS_TGT) begin
                            w_state      = HUNT;
                            w_verify_cnt = 8'd0;
                            w_miss_cnt   = 8'd0;
                        end else begin
                            w_miss_cnt = w_miss_inc;
                        end
                    end
                end

                default: begin
                    w_state = HUNT;
                end
            endcase
        end
    end

    assign w_fifo_rd = out_ready & ~w_fifo_empty;

    pam4_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (r_wr_en),
        .wr_data (r_wr_data),
        .full    (w_fifo_full),
        .rd_en   (out_ready),
        .rd_data (w_fifo_data),
        .empty   (w_fifo_empty)
    );

    assign out_valid   = ~w_fifo_empty;
    assign out_data    = w_fifo_empty ? 8'h00 : w_fifo_data;
    assign locked      = (r_state == LOCKED);
    assign state       = r_state;
    assign sym_err_cnt = r_sym_err_cnt;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pam4_frame_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_pam4_frame_sync
// Brief    : Directed self-checking bench for pam4_frame_sync.
// Revision : 1.0
// ============================================================================
module tb_pam4_frame_sync;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_en;
    logic [3:0] s_in;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       locked;
    logic [1:0] state;
    logic [7:0] sym_err_cnt;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] got [$];
    logic [7:0] exp_q [$];

    pam4_frame_sync dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en   (sample_en),
        .s_in        (s_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .locked      (locked),
        .state       (state),
        .sym_err_cnt (sym_err_cnt),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got.push_back(out_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] enc(input logic [1:0] b);
        case (b)
            2'b00:   return 4'b1101;
            2'b01:   return 4'b1111;
            2'b11:   return 4'b0001;
            default: return 4'b0011;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe followed by one idle cycle; returns 1 time unit after the strobe edge.
    task automatic send_sym(input logic [3:0] v);
        @(posedge clk);
        #1;
        sample_en = 1'b1;
        s_in      = v;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int k = 3; k >= 0; k--) begin
            send_sym(enc(b[2*k +: 2]));
        end
    endtask

    task automatic send_payload(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send_byte(8'(i));
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sample_en = 1'b0;
        s_in      = 4'b0000;
        idle(2);
        rst_n = 1'b1;
        got.delete();
    endtask

    task automatic chk_got(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk(tag, (i < got.size()) ? got[i] : 8'hEE, exp_q[i]);
        end
    endtask

    task automatic payload_exp(input int first, input int last);
        exp_q.delete();
        for (int i = first; i <= last; i++) begin
            exp_q.push_back(8'(i));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sample_en = 1'b0;
        s_in      = 4'b0000;
        out_ready = 1'b0;
        idle(2);
        chk("rst_state", state, 2'b00);
        chk("rst_locked", locked, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_err", sym_err_cnt, 8'h00);
        chk("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;

        // Clean lock
        out_ready = 1'b1;
        send_byte(8'h3C);
        chk("clean_verify", state, 2'b01);
        send_payload(1, 15);
        chk("clean_still_verify", state, 2'b01);
        chk("clean_no_out", got.size(), 0);
        send_byte(8'h3C);
        chk("clean_locked_state", state, 2'b10);
        chk("clean_locked", locked, 1'b1);
        send_payload(1, 15);
        idle(4);
        payload_exp(1, 15);
        chk_got("clean_data");

        // Misaligned by one leading symbol
        do_reset();
        send_sym(enc(2'b11));
        send_byte(8'h3C);
        send_payload(1, 15);
        send_byte(8'h3C);
        send_payload(1, 15);
        idle(4);
        chk("mis_locked", state, 2'b10);
        chk_got("mis_data");

        // Sync loss after three corrupted SYNC bytes
        got.delete();
        send_byte(8'h00);
        send_payload(1, 15);
        send_byte(8'h00);
        chk("loss_miss2_locked", state, 2'b10);
        send_payload(1, 13);
        idle(3);
        out_ready = 1'b0;
        send_payload(14, 15);
        send_byte(8'h00);
        chk("loss_state", state, 2'b00);
        chk("loss_locked", locked, 1'b0);
        chk("loss_valid", out_valid, 1'b1);
        chk("loss_head", out_data, 8'h0E);
        got.delete();
        out_ready = 1'b1;
        idle(4);
        exp_q.delete();
        exp_q.push_back(8'h0E);
        exp_q.push_back(8'h0F);
        chk_got("loss_drain");
        chk("loss_empty", out_valid, 1'b0);

        // Invalid symbols
        do_reset();
        send_sym(4'b0000);
        chk("inv_one_err", sym_err_cnt, 8'd1);
        chk("inv_one_state", state, 2'b00);
        @(posedge clk);
        #1;
        sample_en = 1'b1;
        s_in      = 4'b0000;
        repeat (299) @(posedge clk);
        #1;
        sample_en = 1'b0;
        chk("inv_sat", sym_err_cnt, 8'd255);
        send_sym(4'b1000);
        chk("inv_sat_hold", sym_err_cnt, 8'd255);
        chk("inv_no_lock", state, 2'b00);
        send_byte(8'h3C);
        chk("inv_verify", state, 2'b01);
        send_sym(4'b0101);
        chk("inv_verify_drop", state, 2'b00);

        // Backpressure and overflow
        do_reset();
        out_ready = 1'b0;
        send_byte(8'h3C);
        send_payload(1, 15);
        send_byte(8'h3C);
        send_payload(1, 4);
        idle(2);
        chk("bp_ovf_before", overflow, 1'b0);
        chk("bp_valid", out_valid, 1'b1);
        send_byte(8'h05);
        idle(2);
        chk("bp_ovf", overflow, 1'b1);
        chk("bp_head", out_data, 8'h01);
        chk("bp_locked", locked, 1'b1);

        // Full FIFO with read and write in the same cycle
        send_byte(8'h06);
        got.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        idle(1);
        chk("rw_head", out_data, 8'h02);
        out_ready = 1'b1;
        idle(6);
        exp_q.delete();
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h06);
        chk_got("rw_data");
        chk("rw_ovf_sticky", overflow, 1'b1);

        // Asynchronous reset in the middle of a byte
        out_ready = 1'b0;
        send_byte(8'h07);
        idle(2);
        chk("ar_pre_valid", out_valid, 1'b1);
        send_sym(enc(2'b01));
        send_sym(enc(2'b01));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_state", state, 2'b00);
        chk("ar_locked", locked, 1'b0);
        chk("ar_valid", out_valid, 1'b0);
        chk("ar_data", out_data, 8'h00);
        chk("ar_err", sym_err_cnt, 8'h00);
        chk("ar_ovf", overflow, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
